uart_rx_fifo: RTL and testbench

Receive buffer that sits directly downstream of `uart_rx`: it captures each byte presented on `rx_data` when `rx_end` pulses, queues the bytes in a circular FIFO, and delivers them to the bus-side register logic through a one-cycle-latency read handshake. It decouples the serial byte rate from CPU polling. It also reports occupancy, a sticky overrun flag and a threshold interrupt.

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 83 ++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream and bus-side read handshake bundle for the UART receive FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              rx_end;
  logic [7:0]        rx_data;
  logic              rd_req;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              ovr_clr;
  logic              irq;

  modport master (
    output rx_end, rx_data, rd_req, ovr_clr,
    input  rd_data, rd_valid, count, empty, full, overrun, irq
  );

  modport slave (
    input  rx_end, rx_data, rd_req, ovr_clr,
    output rd_data, rd_valid, count, empty, full, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO between uart_rx and the bus read port, with occupancy,
// sticky overrun and threshold interrupt reporting.
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned THRESH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [CNT_W-1:0]  count_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              overrun_q;

  logic full_c;
  logic empty_c;
  logic wr_acc_c;
  logic rd_acc_c;
  logic drop_c;

  // Flags come straight from registered count so they never glitch.
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  // A full FIFO still takes a byte when a read frees a slot in the same cycle.
  assign wr_acc_c = bus.rx_end & (~full_c | bus.rd_req);
  assign rd_acc_c = bus.rd_req & ~empty_c;
  assign drop_c   = bus.rx_end & full_c & ~bus.rd_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_c;
      if (wr_acc_c) begin
        wp <= wp + ADDR_W'(1);
      end
      if (rd_acc_c) begin
        rp        <= rp + ADDR_W'(1);
        rd_data_q <= mem[rp];
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A new drop outranks a clear in the same cycle.
      if (drop_c) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Storage is intentionally left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wp] <= bus.rx_data;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;
  assign bus.overrun  = overrun_q;
  assign bus.irq      = (count_q >= CNT_W'(THRESH)) | overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized check of uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned THRESH = 8;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .THRESH(THRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus the visible read register and flag.
  logic [7:0] q [$];
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(bus.count),    32'(q.size()));
    check({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
    check({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
    check({tag, ".overrun"},  32'(bus.overrun),  32'(m_ovr));
    check({tag, ".irq"},      32'(bus.irq),      32'((q.size() >= THRESH) || m_ovr));
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_valid));
    check({tag, ".rd_data"},  32'(bus.rd_data),  32'(m_data));
  endtask

  // One clock of stimulus; the model advances from its own pre-edge state.
  task automatic step(input logic rx, input logic [7:0] d, input logic rd, input logic clr,
                      input string tag);
    bit was_full;
    bus.rx_end  = rx;
    bus.rx_data = d;
    bus.rd_req  = rd;
    bus.ovr_clr = clr;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    m_valid  = 1'b0;
    if (rd && q.size() > 0) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end
    if (rx && (!was_full || rd)) q.push_back(d);
    if (rx && was_full && !rd) m_ovr = 1'b1;
    else if (clr)              m_ovr = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [7:0] d, input string tag);
    step(1'b1, d, 1'b0, 1'b0, tag);
  endtask

  task automatic rd(input string tag);
    step(1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  initial begin
    bus.rx_end  = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_req  = 1'b0;
    bus.ovr_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Ordering
    wr(8'hA5, "ord_w0");
    wr(8'h3C, "ord_w1");
    wr(8'h00, "ord_w2");
    rd("ord_r0");
    check("ord_r0.byte", 32'(bus.rd_data), 32'h A5);
    rd("ord_r1");
    check("ord_r1.byte", 32'(bus.rd_data), 32'h3C);
    rd("ord_r2");
    check("ord_r2.byte", 32'(bus.rd_data), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, "ord_idle");

    // Fill and wrap
    for (int i = 0; i < 16; i++) wr(8'(i), "fill");
    check("fill.full_const", 32'(bus.full), 32'd1);
    for (int i = 0; i < 4; i++) rd("wrap_r4");
    for (int i = 0; i < 4; i++) wr(8'(8'h10 + i), "wrap_w");
    for (int i = 0; i < 16; i++) begin
      rd("wrap_drain");
      check("wrap_drain.seq", 32'(bus.rd_data), 32'(8'h04 + i));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, "wrap_idle");

    // Overrun
    for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 8'hFE)), "ovr_fill");
    wr(8'hFF, "ovr_drop");
    check("ovr_drop.set", 32'(bus.overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr");
    check("ovr_clr.cleared", 32'(bus.overrun), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, "ovr_clr_and_drop");
    check("ovr_clr_and_drop.kept", 32'(bus.overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, "ovr_clr2");

    // Simultaneous on full, then drain; 8'h77 must come out last
    step(1'b1, 8'h77, 1'b1, 1'b0, "sim_full");
    check("sim_full.count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) rd("sim_drain");
    check("sim_drain.last", 32'(bus.rd_data), 32'h77);

    // Simultaneous on empty
    step(1'b1, 8'h77, 1'b1, 1'b0, "sim_empty");
    check("sim_empty.no_valid", 32'(bus.rd_valid), 32'd0);
    rd("sim_empty_rd");
    check("sim_empty_rd.byte", 32'(bus.rd_data), 32'h77);

    // Empty read
    rd("empty_rd");
    wr(8'h5A, "empty_wr");
    rd("empty_rd2");

    // Randomized traffic: a filling phase then a draining phase
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 19) == 0), "rand_fill");
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 9) < 4), 8'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 9) == 0), "rand_drain");

    // Asynchronous reset mid-cycle with queued data
    for (int i = 0; i < 10; i++) wr(8'($urandom), "prerst_w");
    step(1'b1, 8'hEE, 1'b0, 1'b0, "prerst_drop");
    step(1'b1, 8'h11, 1'b1, 1'b0, "prerst_rd");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.rx_end = 1'b0;
    bus.rd_req = 1'b0;
    check_all("async_reset_hold");
    wr(8'hC3, "postrst_w");
    rd("postrst_r");
    check("postrst_r.byte", 32'(bus.rd_data), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
